// File: rtl/period_meter.sv
// period_meter: rise-to-rise period and high-phase timer of an async square wave; high_time only with PERIOD_METER_DUTY_EN
module period_meter #(
    parameter int MAX_PERIOD = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in,
    output logic [27:0] period,
    output logic [27:0] high_time,
    output logic        valid,
    output logic        timeout
);
    typedef enum logic {IDLE, MEASURE} state_t;
    localparam logic [27:0] LAST = 28'(MAX_PERIOD - 1);
    state_t state, state_n;
    logic in_m, in_s, in_d, rise, meas, expire, run;
    logic [27:0] cnt;
    assign rise = in_s & ~in_d;
    assign run = (state == MEASURE) && !rise && !expire;
    always_ff @(posedge clk) begin
        if (rst) begin
            in_m <= 1'b0;
            in_s <= 1'b0;
            in_d <= 1'b0;
        end else begin
            in_m <= in;
            in_s <= in_m;
            in_d <= in_s;
        end
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        meas    = (state == MEASURE) && rise;
        expire  = (state == MEASURE) && !rise && (cnt == LAST);
        state_n = rise ? MEASURE : (expire ? IDLE : state);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid   <= meas;
            cnt     <= rise ? 28'd0 : (run ? cnt + 28'd1 : cnt);
            period  <= meas ? cnt + 28'd1 : period;
            timeout <= meas ? 1'b0 : (expire ? 1'b1 : timeout);
        end
    end
`ifdef PERIOD_METER_DUTY_EN
    logic [27:0] hcnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt      <= '0;
            high_time <= '0;
        end else begin
            hcnt      <= rise ? 28'd1 : ((run && in_s) ? hcnt + 28'd1 : hcnt);
            high_time <= meas ? hcnt : high_time;
        end
    end
`else
    assign high_time = '0;
`endif
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: random square waves vs. an edge-timestamp reference model
module tb_period_meter;
    localparam int MAXP = 16;
`ifdef PERIOD_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, in = 1'b0;
    logic [27:0] period, high_time;
    logic valid, timeout;
    int vectors = 0, miscompares = 0;
    bit hist [0:19999];
    int n = 0, e_prev = 0, hi = 0;
    bit armed = 1'b0;
    logic [27:0] m_period = '0, m_high = '0;
    logic m_valid = 1'b0, m_timeout = 1'b0;

    period_meter #(.MAX_PERIOD(MAXP)) dut (
        .clk(clk), .rst(rst), .in(in),
        .period(period), .high_time(high_time), .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n, got, exp);
        end
    endtask

    function automatic bit h(input int k);
        return (k < 0) ? 1'b0 : hist[k];
    endfunction

    // hist[k] is the input captured by the first synchronizer flop at edge k
    task automatic step(input bit v, input bit r);
        bit rs;
        @(negedge clk);
        in = v;
        rst = r;
        @(posedge clk);
        hist[n] = r ? 1'b0 : v;
        if (r) begin
            if (n >= 1) hist[n-1] = 1'b0;
            if (n >= 2) hist[n-2] = 1'b0;
            armed = 1'b0;
            hi = 0;
            m_period = '0;
            m_high = '0;
            m_valid = 1'b0;
            m_timeout = 1'b0;
        end else begin
            rs = h(n-2) & ~h(n-3);
            m_valid = 1'b0;
            if (armed && rs) begin
                m_period = 28'(n - e_prev);
                m_high = DUTY ? 28'(hi) : 28'd0;
                m_valid = 1'b1;
                m_timeout = 1'b0;
                e_prev = n;
                hi = 1;
            end else if (armed && (n - e_prev == MAXP)) begin
                m_timeout = 1'b1;
                armed = 1'b0;
            end else if (armed) begin
                hi += int'(h(n-2));
            end else if (rs) begin
                armed = 1'b1;
                e_prev = n;
                hi = 1;
            end
        end
        n++;
        #1;
        check("valid", 28'(valid), 28'(m_valid));
        check("period", period, m_period);
        check("high_time", high_time, m_high);
        check("timeout", 28'(timeout), 28'(m_timeout));
    endtask

    task automatic wave(input int hc, input int lc, input int reps);
        repeat (reps) begin
            repeat (hc) step(1'b1, 1'b0);
            repeat (lc) step(1'b0, 1'b0);
        end
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b1);
        wave(2, 2, 8);
        check("steady_p4", period, 28'd4);
        check("steady_h2", high_time, DUTY ? 28'd2 : 28'd0);
        wave(3, 7, 5);
        check("steady_p10", period, 28'd10);
        check("steady_h3", high_time, DUTY ? 28'd3 : 28'd0);
        wave(2, 2, 4);
        repeat (20) step(1'b0, 1'b0);
        check("stall_timeout", 28'(timeout), 28'd1);
        check("stall_hold_p4", period, 28'd4);
        wave(1, 5, 4);
        check("recover_p6", period, 28'd6);
        wave(3, 13, 4);
        check("edge_p16", period, 28'd16);
        check("edge_no_timeout", 28'(timeout), 28'd0);
        wave(1, 16, 3);
        wave(2, 2, 3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        wave(2, 2, 5);
        check("post_reset_p4", period, 28'd4);
        repeat (60) begin
            wave($urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(1, 4));
            if ($urandom_range(0, 9) == 0) step(in, 1'b1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
